dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller_if.sv | 40 ++++
 rtl/dma_controller.sv | 150 +++++++++++++++
 tb/tb_dma_controller.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_if.sv
// Bus bundle for dma_controller: programming inputs, CPU hold handshake,
// DRAM/IO address and strobe outputs, and the data path.
// The master modport is the DMA side; slave is the system/CPU side.
interface dma_controller_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] DRAM_startingAddress;
  logic [ADDR_WIDTH-1:0] IO_startingAddress;
  logic [ADDR_WIDTH-1:0] addressCounter;
  logic                  IOR;
  logic                  IOW;
  logic                  LOAD;
  logic                  HLDA;
  logic                  HRQ;
  logic                  EOP;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [ADDR_WIDTH-1:0] IO_ADDR;
  logic                  MEM_RD;
  logic                  MEM_WR;
  logic                  IO_RD;
  logic                  IO_WR;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  BUSY;

  modport master (
    input  DRAM_startingAddress, IO_startingAddress, addressCounter,
    input  IOR, IOW, LOAD, HLDA, DATA_IN,
    output HRQ, EOP, MEM_ADDR, IO_ADDR, MEM_RD, MEM_WR, IO_RD, IO_WR,
    output DATA_OUT, BUSY
  );

  modport slave (
    output DRAM_startingAddress, IO_startingAddress, addressCounter,
    output IOR, IOW, LOAD, HLDA, DATA_IN,
    input  HRQ, EOP, MEM_ADDR, IO_ADDR, MEM_RD, MEM_WR, IO_RD, IO_WR,
    input  DATA_OUT, BUSY
  );
endinterface

// File: rtl/dma_controller.sv
// Single-channel DMA controller moving words between an IO device and DRAM,
// one word every two cycles (read then write), under a CPU hold handshake.
// Optional macro DMA_AUTOINIT_EN: keep the programmed values in shadow
// registers and restart the same block after every end-of-process.
//
// state | meaning
// IDLE  | waiting for a valid LOAD
// REQ   | bus requested (HRQ high), waiting for HLDA
// RD    | source read strobe high, DATA_IN captured at the closing edge
// WR    | destination write strobe high, addresses/count step at the close
// DONE  | one-cycle EOP low, HRQ low
module dma_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic             CLK,
  input logic             RST_N,
  dma_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state;
  logic                  dir_ior;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [ADDR_WIDTH-1:0] io_addr;
  logic [DATA_WIDTH-1:0] data_hold;
  logic                  hrq;
  logic                  eop;
  logic                  busy;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  io_rd;
  logic                  io_wr;

`ifdef DMA_AUTOINIT_EN
  // Reload source for every restart; IDLE is never re-entered after the
  // first block, so later LOADs are ignored until reset.
  logic [ADDR_WIDTH-1:0] sh_mem_addr;
  logic [ADDR_WIDTH-1:0] sh_io_addr;
  logic [ADDR_WIDTH-1:0] sh_count;
`endif

  // Transfer sequencer: state, addresses, count, data holding register and
  // every output are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      dir_ior   <= 1'b0;
      count     <= '0;
      mem_addr  <= '0;
      io_addr   <= '0;
      data_hold <= '0;
      hrq       <= 1'b0;
      eop       <= 1'b1;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
`ifdef DMA_AUTOINIT_EN
      sh_mem_addr <= '0;
      sh_io_addr  <= '0;
      sh_count    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.LOAD && (bus.IOR ^ bus.IOW) && (bus.addressCounter != '0)) begin
            mem_addr <= bus.DRAM_startingAddress;
            io_addr  <= bus.IO_startingAddress;
            count    <= bus.addressCounter;
            dir_ior  <= bus.IOR;
`ifdef DMA_AUTOINIT_EN
            sh_mem_addr <= bus.DRAM_startingAddress;
            sh_io_addr  <= bus.IO_startingAddress;
            sh_count    <= bus.addressCounter;
`endif
            state <= REQ;
            hrq   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (bus.HLDA) begin
            state  <= RD;
            io_rd  <= dir_ior;
            mem_rd <= ~dir_ior;
          end
        end
        RD: begin
          // The word always finishes, even if HLDA drops now.
          data_hold <= bus.DATA_IN;
          io_rd     <= 1'b0;
          mem_rd    <= 1'b0;
          mem_wr    <= dir_ior;
          io_wr     <= ~dir_ior;
          state     <= WR;
        end
        WR: begin
          mem_wr   <= 1'b0;
          io_wr    <= 1'b0;
          mem_addr <= mem_addr + ONE;
          io_addr  <= io_addr + ONE;
          count    <= count - ONE;
          if (count == ONE) begin
            state <= DONE;
            hrq   <= 1'b0;
            eop   <= 1'b0;
          end else if (bus.HLDA) begin
            state  <= RD;
            io_rd  <= dir_ior;
            mem_rd <= ~dir_ior;
          end else begin
            state <= REQ;
          end
        end
        DONE: begin
          eop <= 1'b1;
`ifdef DMA_AUTOINIT_EN
          mem_addr <= sh_mem_addr;
          io_addr  <= sh_io_addr;
          count    <= sh_count;
          hrq      <= 1'b1;
          state    <= REQ;
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.HRQ      = hrq;
  assign bus.EOP      = eop;
  assign bus.BUSY     = busy;
  assign bus.MEM_ADDR = mem_addr;
  assign bus.IO_ADDR  = io_addr;
  assign bus.MEM_RD   = mem_rd;
  assign bus.MEM_WR   = mem_wr;
  assign bus.IO_RD    = io_rd;
  assign bus.IO_WR    = io_wr;
  assign bus.DATA_OUT = data_hold;

endmodule

// File: tb/tb_dma_controller.sv
// Randomized bench for dma_controller. Expected transfers are built as a
// list of (strobe, address, data) events from the programmed block, and the
// strobes seen on the bus are compared against that list.
module tb_dma_controller;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [1:0]    kind;   // 0 IO_RD, 1 MEM_RD, 2 MEM_WR, 3 IO_WR
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dma_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] io_mem [DEPTH];
  logic [DW-1:0] dram_mem [DEPTH];

  // Source devices answer with the word at the strobed address.
  always_comb begin
    bus.DATA_IN = 32'hDEAD_BEEF;
    if (bus.IO_RD) bus.DATA_IN = io_mem[bus.IO_ADDR];
    else if (bus.MEM_RD) bus.DATA_IN = dram_mem[bus.MEM_ADDR];
  end

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_mem_addr = '0;
  logic [AW-1:0] exp_io_addr = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic int nstrobe();
    return int'(bus.MEM_RD) + int'(bus.MEM_WR) + int'(bus.IO_RD) + int'(bus.IO_WR);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_hrq"}, 64'(bus.HRQ), 64'd0);
    check({tag, "_eop"}, 64'(bus.EOP), 64'd1);
    check({tag, "_busy"}, 64'(bus.BUSY), 64'd0);
    check({tag, "_strobes"}, 64'(nstrobe()), 64'd0);
  endtask

  // mode: 0 HLDA high, 1 grant after 5 REQ cycles, 2 random HLDA,
  //       3 HLDA dropped during word 2, 4 LOAD pulsed while busy
  task automatic run_xfer(input logic [AW-1:0] dram, input logic [AW-1:0] io,
                          input logic [AW-1:0] cnt, input bit ior,
                          input int mode, input bit do_load);
    ev_t obs[$];
    ev_t exp[$];
    int nrd = 0;
    int neop = 0;
    int dcyc = 0;
    bit done = 1'b0;
    bit dropped = 1'b0;
    for (int i = 0; i < int'(cnt); i++) begin
      logic [AW-1:0] s;
      logic [AW-1:0] d;
      s = (ior ? io : dram) + AW'(i);
      d = (ior ? dram : io) + AW'(i);
      exp.push_back('{ior ? 2'd0 : 2'd1, s, '0});
      exp.push_back('{ior ? 2'd2 : 2'd3, d, ior ? io_mem[s] : dram_mem[s]});
    end
    if (do_load) begin
      @(negedge clk);
      bus.DRAM_startingAddress = dram;
      bus.IO_startingAddress   = io;
      bus.addressCounter       = cnt;
      bus.IOR  = ior;
      bus.IOW  = ~ior;
      bus.LOAD = 1'b1;
      bus.HLDA = (mode != 1);
      @(negedge clk);
      bus.LOAD = 1'b0;
      check("hrq_after_load", 64'(bus.HRQ), 64'd1);
      check("busy_after_load", 64'(bus.BUSY), 64'd1);
    end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (nstrobe() != 0) begin
        ev_t e;
        check("strobe_overlap", 64'(nstrobe() > 1), 64'd0);
        e.kind = bus.IO_RD ? 2'd0 : bus.MEM_RD ? 2'd1 : bus.MEM_WR ? 2'd2 : 2'd3;
        e.addr = (e.kind == 2'd0 || e.kind == 2'd3) ? bus.IO_ADDR : bus.MEM_ADDR;
        e.data = (e.kind >= 2'd2) ? bus.DATA_OUT : '0;
        obs.push_back(e);
        if (e.kind < 2'd2) nrd++;
      end
      if (!bus.EOP) begin
        neop++;
        check("hrq_in_done", 64'(bus.HRQ), 64'd0);
        check("busy_in_done", 64'(bus.BUSY), 64'd1);
        done = 1'b1;
      end
      case (mode)
        1: begin
          if (cyc <= 3) begin
            check("req_hold_hrq", 64'(bus.HRQ), 64'd1);
            check("req_hold_quiet", 64'(nstrobe()), 64'd0);
          end
          if (cyc == 3) bus.HLDA = 1'b1;
          if (cyc == 4) check("rd_after_grant", 64'(bus.MEM_RD), 64'd1);
        end
        2: bus.HLDA = ($urandom_range(3) != 0);
        3: begin
          if (!dropped && nrd == 2 && (bus.IO_RD || bus.MEM_RD)) begin
            bus.HLDA = 1'b0;
            dropped = 1'b1;
          end else if (dropped && dcyc < 6) begin
            dcyc++;
            if (dcyc >= 2) begin
              check("pause_hrq", 64'(bus.HRQ), 64'd1);
              check("pause_quiet", 64'(nstrobe()), 64'd0);
            end
            if (dcyc == 6) bus.HLDA = 1'b1;
          end
        end
        4: begin
          if (cyc == 2) begin
            bus.DRAM_startingAddress = AW'($urandom);
            bus.IO_startingAddress   = AW'($urandom);
            bus.addressCounter       = 7;
            bus.IOR  = ~ior;
            bus.IOW  = ior;
            bus.LOAD = 1'b1;
          end else if (cyc == 3) begin
            bus.LOAD = 1'b0;
          end
        end
        default: ;
      endcase
    end
    check("eop_reached", 64'(done), 64'd1);
    check("eop_pulses", 64'(neop), 64'd1);
    if (mode == 3) check("hlda_dropped", 64'(dropped), 64'd1);
    check("n_events", 64'(obs.size()), 64'(exp.size()));
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      check($sformatf("ev%0d_kind", i), 64'(obs[i].kind), 64'(exp[i].kind));
      check($sformatf("ev%0d_addr", i), 64'(obs[i].addr), 64'(exp[i].addr));
      check($sformatf("ev%0d_data", i), 64'(obs[i].data), 64'(exp[i].data));
    end
    exp_mem_addr = dram + cnt;
    exp_io_addr  = io + cnt;
`ifndef DMA_AUTOINIT_EN
    @(negedge clk);
    check_quiet("after_done");
    check("mem_addr_end", 64'(bus.MEM_ADDR), 64'(exp_mem_addr));
    check("io_addr_end", 64'(bus.IO_ADDR), 64'(exp_io_addr));
    if (exp.size() > 0) check("data_out_end", 64'(bus.DATA_OUT), 64'(exp[exp.size()-1].data));
`endif
  endtask

  task automatic invalid_loads();
    logic [AW-1:0] cnts [3];
    logic [1:0]    dirs [3];
    cnts = '{10'd0, 10'd5, 10'd5};
    dirs = '{2'b10, 2'b11, 2'b00};
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      bus.DRAM_startingAddress = AW'($urandom);
      bus.IO_startingAddress   = AW'($urandom);
      bus.addressCounter       = cnts[p];
      bus.IOR  = dirs[p][1];
      bus.IOW  = dirs[p][0];
      bus.LOAD = 1'b1;
      @(negedge clk);
      bus.LOAD = 1'b0;
      check_quiet($sformatf("bad_load%0d", p));
      check($sformatf("bad_load%0d_mem_addr", p), 64'(bus.MEM_ADDR), 64'(exp_mem_addr));
      @(negedge clk);
      check($sformatf("bad_load%0d_hrq_later", p), 64'(bus.HRQ), 64'd0);
    end
  endtask

  task automatic reset_mid_word();
    bit seen = 1'b0;
    @(negedge clk);
    bus.DRAM_startingAddress = 10'h055;
    bus.IO_startingAddress   = 10'h0AA;
    bus.addressCounter       = 4;
    bus.IOR  = 1'b0;
    bus.IOW  = 1'b1;
    bus.LOAD = 1'b1;
    bus.HLDA = 1'b1;
    @(negedge clk);
    bus.LOAD = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.IO_WR) seen = 1'b1;
    end
    check("rst_mid_wr_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("rst_mid_rd_active", 64'(bus.MEM_RD), 64'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_mid");
    check("rst_mid_mem_addr", 64'(bus.MEM_ADDR), 64'd0);
    check("rst_mid_io_addr", 64'(bus.IO_ADDR), 64'd0);
    check("rst_mid_data_out", 64'(bus.DATA_OUT), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_mem_addr = '0;
    exp_io_addr  = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      check("post_rst_eop", 64'(bus.EOP), 64'd1);
      check("post_rst_busy", 64'(bus.BUSY), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      io_mem[i]   = $urandom;
      dram_mem[i] = $urandom;
    end
    bus.DRAM_startingAddress = '0;
    bus.IO_startingAddress   = '0;
    bus.addressCounter       = '0;
    bus.IOR  = 1'b0;
    bus.IOW  = 1'b0;
    bus.LOAD = 1'b0;
    bus.HLDA = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    check("in_reset_mem_addr", 64'(bus.MEM_ADDR), 64'd0);
    check("in_reset_io_addr", 64'(bus.IO_ADDR), 64'd0);
    check("in_reset_data_out", 64'(bus.DATA_OUT), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_reset");

`ifdef DMA_AUTOINIT_EN
    run_xfer(10'h040, 10'h080, 2, 1'b1, 0, 1'b1);
    run_xfer(10'h040, 10'h080, 2, 1'b1, 0, 1'b0);
    run_xfer(10'h040, 10'h080, 2, 1'b1, 0, 1'b0);
`else
    run_xfer(10'h010, 10'h020, 3, 1'b1, 0, 1'b1);
    run_xfer(10'h100, 10'h200, 1, 1'b0, 1, 1'b1);
    run_xfer(10'h3FE, 10'h050, 3, 1'b1, 0, 1'b1);
    run_xfer(AW'($urandom), AW'($urandom), 4, 1'($urandom), 3, 1'b1);
    invalid_loads();
    run_xfer(AW'($urandom), AW'($urandom), 4, 1'($urandom), 4, 1'b1);
    for (int t = 0; t < 6; t++) begin
      run_xfer(AW'($urandom), AW'($urandom), AW'($urandom_range(6, 1)),
               1'($urandom), 2, 1'b1);
    end
    reset_mid_word();
    run_xfer(10'h3FF, 10'h3FD, 5, 1'b0, 2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
